pepe_sum_accum: RTL and testbench
=================================

PEPE_SUM_ACCUM -- requirements
Module: pepe_sum_accum

Interface
REQ-001 SHALL have parameter COUNT, default 4, meaning samples per accumulated block; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  8  sample, i.e. the 8-bit operand sum from the upstream adder stage.
REQ-005 SHALL have port in_valid  input  1  in_data is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port flush  input  1  close the current partial block early.
REQ-008 SHALL have port out_data  output  12  accumulated block sum.
REQ-009 SHALL have port out_cnt  output  8  number of samples in the presented block.
REQ-010 SHALL have port out_ovf  output  1  a carry beyond bit 11 occurred in the presented block.
REQ-011 SHALL have port out_valid  output  1  out_data, out_cnt and out_ovf are valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.

Function
REQ-013 SHALL implement the FSM states IDLE (no samples held), ACC (1..COUNT-1 samples held) and HOLD (result presented).
REQ-014 SHALL define a sample as accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC and in_ready=0 in HOLD; in_ready SHALL NOT depend combinationally on out_ready.
REQ-016 SHALL transition IDLE->ACC on an accept when COUNT>1; IDLE->HOLD on an accept when COUNT=1.
REQ-017 SHALL transition ACC->HOLD when an accept brings the held count to COUNT.
REQ-018 SHALL transition ACC->HOLD on flush=1 with no accept; flush with a simultaneous accept SHALL include that sample and then go to HOLD.
REQ-019 SHALL ignore flush in IDLE when there is no accept; flush in IDLE with an accept SHALL go to HOLD with out_cnt=1.
REQ-020 SHALL ignore flush in HOLD.
REQ-021 SHALL assert out_valid only in HOLD, from the cycle after the closing edge; latency from the final accept to out_valid is 1 cycle.
REQ-022 SHALL hold out_data, out_cnt and out_ovf stable while out_valid=1 and out_ready=0.
REQ-023 SHALL transition HOLD->IDLE on out_valid=1 and out_ready=1, clearing the accumulator, count and overflow flag in the same edge.
REQ-024 SHALL zero-extend in_data to 13 bits before adding; out_ovf SHALL be set sticky when the sum exceeds 4095.
REQ-025 SHALL give a sustained throughput of one block per COUNT+1 cycles when out_ready is held at 1.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, enter IDLE with accumulator=0, count=0 and overflow=0.
REQ-027 SHALL give the outputs these reset values: out_valid=0, out_data=0, out_cnt=0, out_ovf=0, in_ready=1 from the first cycle after reset.
REQ-028 SHALL discard any partial block or pending result when rst is asserted mid-operation, with no result emitted.

Configuration
REQ-029 SHALL use the macro PEPE_ACC_SAT_EN to select the overflow behaviour.
REQ-030 SHALL, when PEPE_ACC_SAT_EN is defined, clamp the accumulator at 4095 once overflow occurs and keep it there for the rest of the block.
REQ-031 SHALL, when PEPE_ACC_SAT_EN is undefined, wrap the accumulator modulo 4096.
REQ-032 SHALL behave identically for out_ovf in both builds.

Verification
REQ-033 SHALL cover this scenario: COUNT=4, accept 10,20,30,40 back-to-back with out_ready=1 -> out_valid=1 one cycle after the 4th accept with out_data=100, out_cnt=4, out_ovf=0; returns to IDLE next cycle.
REQ-034 SHALL cover this scenario: COUNT=4, accept 5,7, then flush=1 with no in_valid -> out_data=12, out_cnt=2; flush pulse in IDLE -> no out_valid.
REQ-035 SHALL cover this scenario: COUNT=4, accept 1,2,3,4, hold out_ready=0 for 5 cycles -> out_data=10 stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 SHALL cover this scenario: COUNT=20, twenty samples of 255 -> out_ovf=1; out_data=4095 with PEPE_ACC_SAT_EN defined, out_data=5100 mod 4096=1004 without it.
REQ-037 SHALL cover this scenario: COUNT=4, accept 9,9, rst=1 for one cycle, then accept 1,1,1,1 -> single result out_data=4, out_cnt=4; no result containing 9.
REQ-038 SHALL cover this scenario: COUNT=1, in_valid held high with out_ready=1 -> one result every 2 cycles, each out_data equal to the accepted sample.

Source files
------------

// File: rtl/pepe_sum_accum.sv
// pepe_sum_accum: accumulates COUNT samples (or fewer, on flush) into a
// 12-bit block sum and presents it with a ready/valid handshake.
// Build option PEPE_ACC_SAT_EN: when defined, the accumulator clamps at
// 4095 after an overflow; otherwise it wraps modulo 4096.
// out_ovf behaves the same way in both builds.
module pepe_sum_accum #(
  parameter int COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [11:0] out_data,
  output logic [7:0]  out_cnt,
  output logic        out_ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0] COUNT_B = 8'(COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] acc_p0;
  logic [7:0]  cnt_p0;
  logic        ovf_p0;
  logic        accept;
  logic        clear;
  logic [7:0]  cnt_inc;
  logic [12:0] add_res;

`ifdef PEPE_ACC_SAT_EN
  // Bit 12 is the carry of this add; once the block has overflowed the
  // low 12 bits are pinned at full scale.
  function automatic logic [12:0] acc_add(input logic [11:0] acc,
                                          input logic [7:0]  din,
                                          input logic        ovf_in);
    logic [12:0] sum;
    sum = {1'b0, acc} + {5'b0, din};
    if (sum[12] || ovf_in) begin
      return {sum[12], 12'hFFF};
    end
    return sum;
  endfunction
`else
  // Bit 12 is the carry of this add; the low 12 bits wrap modulo 4096.
  function automatic logic [12:0] acc_add(input logic [11:0] acc,
                                          input logic [7:0]  din);
    return {1'b0, acc} + {5'b0, din};
  endfunction
`endif

  assign accept  = in_valid && in_ready;
  assign clear   = (state == HOLD) && out_ready;
  assign cnt_inc = cnt_p0 + 8'd1;

`ifdef PEPE_ACC_SAT_EN
  assign add_res = acc_add(acc_p0, in_data, ovf_p0);
`else
  assign add_res = acc_add(acc_p0, in_data);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((COUNT_B == 8'd1) || flush) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        if (accept && (cnt_inc == COUNT_B)) begin
          state_nxt = HOLD;
        end else if (flush) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulator, sample count and sticky overflow; cleared when the result is taken
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_p0 <= 12'd0;
      cnt_p0 <= 8'd0;
      ovf_p0 <= 1'b0;
    end else if (accept) begin
      acc_p0 <= add_res[11:0];
      cnt_p0 <= cnt_inc;
      ovf_p0 <= ovf_p0 | add_res[12];
    end
  end

  assign out_data = acc_p0;
  assign out_cnt  = cnt_p0;
  assign out_ovf  = ovf_p0;

endmodule

// File: tb/tb_pepe_sum_accum.sv
// Testbench for pepe_sum_accum: three instances (COUNT = 4, 20, 1) share one
// stimulus stream and are compared every cycle against a block-level model
// that tracks the true (unbounded) sum of each block.
module tb_pepe_sum_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [11:0] od  [3];
  logic [7:0]  oc  [3];
  logic        ov  [3];
  logic        ovld[3];
  logic        ir  [3];

  int checks   = 0;
  int failures = 0;

  int msum[3];
  int mn  [3];
  bit mh  [3];

  always #5 clk = ~clk;

  pepe_sum_accum #(.COUNT(4)) u_c4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[0]), .flush(flush), .out_data(od[0]), .out_cnt(oc[0]),
    .out_ovf(ov[0]), .out_valid(ovld[0]), .out_ready(out_ready)
  );

  pepe_sum_accum #(.COUNT(20)) u_c20 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[1]), .flush(flush), .out_data(od[1]), .out_cnt(oc[1]),
    .out_ovf(ov[1]), .out_valid(ovld[1]), .out_ready(out_ready)
  );

  pepe_sum_accum #(.COUNT(1)) u_c1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[2]), .flush(flush), .out_data(od[2]), .out_cnt(oc[2]),
    .out_ovf(ov[2]), .out_valid(ovld[2]), .out_ready(out_ready)
  );

  function automatic int count_of(int i);
    case (i)
      0:       return 4;
      1:       return 20;
      default: return 1;
    endcase
  endfunction

  // Presented value of a block whose true sum is s
  function automatic int exp_data(int s);
`ifdef PEPE_ACC_SAT_EN
    return (s > 4095) ? 4095 : s;
`else
    return s % 4096;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then
  // compare every instance just after the edge.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        msum[i] = 0; mn[i] = 0; mh[i] = 0;
      end else if (mh[i]) begin
        if (out_ready) begin
          msum[i] = 0; mn[i] = 0; mh[i] = 0;
        end
      end else begin
        if (in_valid) begin
          msum[i] += int'(in_data);
          mn[i]++;
          if (mn[i] == count_of(i) || flush) mh[i] = 1;
        end else if (flush && mn[i] > 0) begin
          mh[i] = 1;
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      string t;
      t = $sformatf("c%0d", count_of(i));
      chk({t, "_valid"}, 32'(ovld[i]), 32'(mh[i]));
      chk({t, "_in_ready"}, 32'(ir[i]), 32'(!mh[i]));
      if (mh[i] || mn[i] == 0) begin
        chk({t, "_data"}, 32'(od[i]), 32'(exp_data(msum[i])));
        chk({t, "_cnt"}, 32'(oc[i]), 32'(mn[i]));
        chk({t, "_ovf"}, 32'(ov[i]), 32'(msum[i] > 4095));
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int samples[4];
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_valid", 32'(ovld[0]), 32'd0);
    chk("reset_in_ready", 32'(ir[0]), 32'd1);
    chk("reset_data", 32'(od[0]), 32'd0);

    // Back-to-back block of four
    samples = '{10, 20, 30, 40};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(samples[k]), 1'b0, 1'b1);
      cycle();
    end
    chk("blk4_valid", 32'(ovld[0]), 32'd1);
    chk("blk4_data", 32'(od[0]), 32'd100);
    chk("blk4_cnt", 32'(oc[0]), 32'd4);
    chk("blk4_ovf", 32'(ov[0]), 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    cycle();
    chk("blk4_idle", 32'(ovld[0]), 32'd0);

    // Flush of a partial block, then a flush pulse while idle
    do_reset();
    drive(1'b1, 8'd5, 1'b0, 1'b1); cycle();
    drive(1'b1, 8'd7, 1'b0, 1'b1); cycle();
    drive(1'b0, 8'd0, 1'b1, 1'b1); cycle();
    chk("flush_valid", 32'(ovld[0]), 32'd1);
    chk("flush_data", 32'(od[0]), 32'd12);
    chk("flush_cnt", 32'(oc[0]), 32'd2);
    drive(1'b0, 8'd0, 1'b0, 1'b1); cycle();
    drive(1'b0, 8'd0, 1'b1, 1'b1); cycle();
    chk("idle_flush_valid", 32'(ovld[0]), 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b1); cycle();
    chk("idle_flush_valid2", 32'(ovld[0]), 32'd0);

    // Backpressure: result held stable, offered samples refused
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'd99, 1'b1, 1'b0);
      cycle();
      chk("stall_data", 32'(od[0]), 32'd10);
      chk("stall_in_ready", 32'(ir[0]), 32'd0);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b1); cycle();
    chk("release_in_ready", 32'(ir[0]), 32'd1);

    // Twenty samples of 255 overflow the COUNT=20 instance
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 8'd255, 1'b0, 1'b1);
      cycle();
    end
    chk("ovf20_valid", 32'(ovld[1]), 32'd1);
    chk("ovf20_ovf", 32'(ov[1]), 32'd1);
`ifdef PEPE_ACC_SAT_EN
    chk("ovf20_data", 32'(od[1]), 32'd4095);
`else
    chk("ovf20_data", 32'(od[1]), 32'd1004);
`endif
    drive(1'b0, 8'd0, 1'b0, 1'b1); cycle();

    // Reset mid-block discards the partial sum
    do_reset();
    drive(1'b1, 8'd9, 1'b0, 1'b1); cycle();
    drive(1'b1, 8'd9, 1'b0, 1'b1); cycle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'd1, 1'b0, 1'b1);
      cycle();
    end
    chk("rst_mid_data", 32'(od[0]), 32'd4);
    chk("rst_mid_cnt", 32'(oc[0]), 32'd4);

    // COUNT=1 streaming: one result every other cycle
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
      cycle();
      chk("c1_stream_valid", 32'(ovld[2]), 32'(k % 2 == 0));
    end

    // Randomized traffic, with occasional flush, backpressure and reset
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) != 0));
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
